// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
//   parity_e      : encoding of the parity_i configuration input
//   state_t       : receiver frame FSM states
//   clamp_bits()  : maps a requested data-bit count onto the supported range
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE3 = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } state_t;

  localparam int unsigned MIN_BAUD_DIV  = 4;
  localparam int unsigned MIN_DATA_BITS = 5;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req > max_bits) return max_bits;
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    return req;
  endfunction

endpackage

// File: rtl/wbit_fifo.sv
// Word FIFO with a registered read port and an occupancy output.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   we_i, wdata_i : push request (ignored while full) and word
//   re_i          : pop request (ignored while empty); head word lands in rdata_o next edge
//   rdata_o       : last popped word, 0 after reset
//   full_o, empty_o, level_o : occupancy status
module wbit_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         re_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push, pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = rdata_q;

  always_comb begin
    push     = we_i && !full_o;
    pop      = re_i && !empty_o;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    rdata_d  = pop ? mem_q[rd_ptr_q] : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..DATA_WIDTH data bits, none/even/odd
// parity, 1 or 2 stop bits, 3-sample majority vote) feeding a flagged word FIFO.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   baud_div_i               : clocks per bit (>= 4)
//   data_bits_i, parity_i, stop2_i : frame format, latched at start of frame
//   rx_en_i                  : enables start detection
//   rx_re_i                  : FIFO read strobe
//   ovr_clr_i                : clears the sticky overrun flag
//   rx_bit_i                 : asynchronous serial line
//   dout_o, perr_o, ferr_o, brk_o : last word read and its flags
//   full_o, empty_o, level_o : FIFO status
//   overrun_o                : sticky, a word was dropped on a full FIFO
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [15:0]                       baud_div_i,
  input  logic [3:0]                        data_bits_i,
  input  logic [1:0]                        parity_i,
  input  logic                              stop2_i,
  input  logic                              rx_en_i,
  input  logic                              rx_re_i,
  input  logic                              ovr_clr_i,
  input  logic                              rx_bit_i,
  output logic [DATA_WIDTH-1:0]             dout_o,
  output logic                              perr_o,
  output logic                              ferr_o,
  output logic                              brk_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              overrun_o
);
  localparam int WW = DATA_WIDTH + 3;

  logic                  sync1_q, sync2_q, rx_s;
  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d, mid;
  logic                  end_tick, vote_tick, vote;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic [3:0]            bit_q, bit_d, nbits_q, nbits_d;
  logic                  par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic [WW-1:0]         wdata_q, wdata_d;
  logic                  ovr_q, ovr_d;
  logic                  commit, brk;
  logic [WW-1:0]         rdata;

  // Synchronizer: idle-high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_bit_i;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  assign mid       = (baud_div_i >> 1) - 16'd1;
  assign end_tick  = (cnt_q == baud_div_i - 16'd1);
  assign vote_tick = (cnt_q == mid + 16'd1);
  // Third sample is the live line value in the vote cycle.
  assign vote      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == ST_IDLE || end_tick) ? 16'd0 : cnt_q + 16'd1;
    s0_d      = (cnt_q == mid - 16'd1) ? rx_s : s0_q;
    s1_d      = (cnt_q == mid) ? rx_s : s1_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    commit    = 1'b0;
    brk       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_en_i && !rx_s) begin
          state_d   = ST_START;
          nbits_d   = clamp_bits(data_bits_i, 4'(DATA_WIDTH));
          par_en_d  = (parity_e'(parity_i) == PAR_EVEN) || (parity_e'(parity_i) == PAR_ODD);
          par_odd_d = (parity_e'(parity_i) == PAR_ODD);
          stop2_d   = stop2_i;
          bit_d     = 4'd0;
          data_d    = '0;
          par_bit_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      ST_START: begin
        if (vote_tick && vote) state_d = ST_IDLE;
        else if (end_tick)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_tick) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_q == 4'(i)) data_d[i] = vote;
          end
        end
        if (end_tick) begin
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = 4'd0;
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (vote_tick) begin
          par_bit_d = vote;
          perr_d    = ((^data_q) ^ vote) != par_odd_q;
        end
        if (end_tick) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (vote_tick) begin
          ferr_d = ferr_q | ~vote;
          commit = !stop2_q;
        end else if (end_tick) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (vote_tick) begin
          ferr_d = ferr_q | ~vote;
          commit = 1'b1;
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The final stop vote ends the frame immediately; the write is registered.
    if (commit) begin
      brk     = ferr_d && (data_q == '0) && !par_bit_q;
      wr_d    = 1'b1;
      wdata_d = {brk, ferr_d, perr_q, data_q};
      state_d = brk ? ST_BRK_WAIT : ST_IDLE;
    end

    // A drop in the same cycle as a clear must leave the flag set.
    if (wr_q && full_o)  ovr_d = 1'b1;
    else if (ovr_clr_i)  ovr_d = 1'b0;
    else                 ovr_d = ovr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      bit_q     <= '0;
      nbits_q   <= 4'(MIN_DATA_BITS);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      ovr_q     <= ovr_d;
    end
  end

  wbit_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_q),
    .wdata_i (wdata_q),
    .re_i    (rx_re_i),
    .rdata_o (rdata),
    .full_o  (full_o),
    .empty_o (empty_o),
    .level_o (level_o)
  );

  assign dout_o    = rdata[DATA_WIDTH-1:0];
  assign perr_o    = rdata[DATA_WIDTH];
  assign ferr_o    = rdata[DATA_WIDTH+1];
  assign brk_o     = rdata[DATA_WIDTH+2];
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg with a word-level reference model.
module tb_uart_rx_cfg;
  localparam int DW    = 9;
  localparam int DEPTH = 4;
  localparam int BAUD  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'(BAUD);
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity = 2'd0;
  logic        stop2 = 1'b0;
  logic        rx_en = 1'b1;
  logic        rx_re = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        rx_bit = 1'b1;
  logic [DW-1:0] dout;
  logic        perr, ferr, brk, full, empty, overrun;
  logic [2:0]  level;

  uart_rx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .data_bits_i(data_bits),
    .parity_i(parity), .stop2_i(stop2), .rx_en_i(rx_en), .rx_re_i(rx_re),
    .ovr_clr_i(ovr_clr), .rx_bit_i(rx_bit), .dout_o(dout), .perr_o(perr),
    .ferr_o(ferr), .brk_o(brk), .full_o(full), .empty_o(empty),
    .level_o(level), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: queue of expected words {brk, ferr, perr, data}, last word read, overrun.
  logic [11:0] m_q[$];
  logic [11:0] m_last = '0;
  logic        m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("level",   32'(level),   32'(m_q.size()));
      check("empty",   32'(empty),   32'(m_q.size() == 0));
      check("full",    32'(full),    32'(m_q.size() == DEPTH));
      check("dout",    32'(dout),    32'(m_last[8:0]));
      check("perr",    32'(perr),    32'(m_last[9]));
      check("ferr",    32'(ferr),    32'(m_last[10]));
      check("brk",     32'(brk),     32'(m_last[11]));
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  function automatic logic [11:0] expect_word(input logic [8:0] d, input int n, input int pmode,
                                              input logic pbit, input logic stop_ok);
    logic [8:0] m;
    logic pen, pe, fe, bk;
    m   = d & 9'((1 << n) - 1);
    pen = (pmode == 1) || (pmode == 2);
    pe  = pen && ((($countones(m) + int'(pbit)) % 2) != ((pmode == 2) ? 1 : 0));
    fe  = !stop_ok;
    bk  = fe && (m == 0) && !(pen && pbit);
    return {bk, fe, pe, m};
  endfunction

  task automatic model_push(input logic [11:0] w);
    if (m_q.size() == DEPTH) m_ovr = 1'b1;
    else m_q.push_back(w);
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic drive(input logic v, input int cycles);
    rx_bit = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    chk_en = 1'b0;
    rx_re = 1'b1;
    @(posedge clk);
    #1;
    rx_re = 1'b0;
    if (m_q.size() != 0) m_last = m_q.pop_front();
    settle();
  endtask

  // pforce < 0 sends the correct parity bit; spike >= 0 puts a one-cycle
  // inverted pulse inside that data bit.
  task automatic send_frame(input logic [8:0] d, input int nreq, input int pmode, input bit two_stop,
                            input int pforce, input int spike, input bit expect_wr);
    int n;
    logic pbit;
    logic [8:0] m;
    n = (nreq > DW) ? DW : ((nreq < 5) ? 5 : nreq);
    m = d & 9'((1 << n) - 1);
    if (pforce >= 0) pbit = pforce[0];
    else pbit = (($countones(m) % 2) == 1) ^ (pmode == 2);
    data_bits = 4'(nreq);
    parity    = 2'(pmode);
    stop2     = two_stop;
    chk_en    = 1'b0;
    drive(1'b0, BAUD);
    for (int i = 0; i < n; i++) begin
      if (i == spike) begin
        drive(m[i], 8);
        drive(~m[i], 1);
        drive(m[i], BAUD - 9);
      end else begin
        drive(m[i], BAUD);
      end
    end
    if (pmode == 1 || pmode == 2) drive(pbit, BAUD);
    drive(1'b1, BAUD);
    if (two_stop) drive(1'b1, BAUD);
    drive(1'b1, 2 * BAUD);
    if (expect_wr) model_push(expect_word(m, n, pmode, pbit, 1'b1));
    settle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values.
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    settle();

    // 8N1 0xA5.
    send_frame(9'h0A5, 8, 0, 1'b0, -1, -1, 1'b1);
    check("a5_level", 32'(level), 32'h1);
    do_read();
    check("a5_dout", 32'(dout), 32'h0A5);
    check("a5_flags", 32'({brk, ferr, perr}), 32'h0);
    check("a5_level_after", 32'(level), 32'h0);

    // 7E2 0x41: wrong parity bit then correct one.
    send_frame(9'h041, 7, 1, 1'b1, 1, -1, 1'b1);
    do_read();
    check("7e2_bad_perr", 32'(perr), 32'h1);
    check("7e2_bad_dout", 32'(dout), 32'h041);
    send_frame(9'h041, 7, 1, 1'b1, 0, -1, 1'b1);
    do_read();
    check("7e2_good_perr", 32'(perr), 32'h0);

    // Odd parity, and parity code 3 meaning none.
    send_frame(9'h003, 8, 2, 1'b0, -1, -1, 1'b1);
    do_read();
    send_frame(9'h080, 8, 3, 1'b0, -1, -1, 1'b1);
    do_read();
    check("par3_dout", 32'(dout), 32'h080);

    // Start glitch of 3 cycles, then a frame with rx_en low.
    chk_en = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 3 * BAUD);
    settle();
    check("glitch_empty", 32'(empty), 32'h1);
    rx_en = 1'b0;
    send_frame(9'h055, 8, 0, 1'b0, -1, -1, 1'b0);
    rx_en = 1'b1;
    check("rxen_off_level", 32'(level), 32'h0);

    // One-cycle spike inside data bit 3 is voted out.
    send_frame(9'h05A, 8, 0, 1'b0, -1, 3, 1'b1);
    do_read();
    check("spike_dout", 32'(dout), 32'h05A);

    // Data-bit clamping: 2 -> 5 bits, 15 -> 9 bits.
    send_frame(9'h1F5, 2, 0, 1'b0, -1, -1, 1'b1);
    do_read();
    check("clamp_lo_dout", 32'(dout), 32'h015);
    send_frame(9'h1AB, 15, 0, 1'b0, -1, -1, 1'b1);
    do_read();
    check("clamp_hi_dout", 32'(dout), 32'h1AB);

    // Break: 12 bit periods low in 8N1.
    data_bits = 4'd8;
    parity = 2'd0;
    stop2 = 1'b0;
    chk_en = 1'b0;
    drive(1'b0, 12 * BAUD);
    drive(1'b1, 4 * BAUD);
    model_push(expect_word(9'h000, 8, 0, 1'b0, 1'b0));
    settle();
    check("brk_level", 32'(level), 32'h1);
    do_read();
    check("brk_word", 32'({brk, ferr, perr, dout}), 32'hC00);

    // Overrun with 5 words into a 4-deep FIFO.
    send_frame(9'h011, 8, 0, 1'b0, -1, -1, 1'b1);
    send_frame(9'h022, 8, 0, 1'b0, -1, -1, 1'b1);
    send_frame(9'h033, 8, 0, 1'b0, -1, -1, 1'b1);
    send_frame(9'h044, 8, 0, 1'b0, -1, -1, 1'b1);
    send_frame(9'h055, 8, 0, 1'b0, -1, -1, 1'b1);
    check("ovr_full", 32'(full), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    do_read();
    check("ovr_first", 32'(dout), 32'h011);
    do_read();
    do_read();
    do_read();
    check("ovr_fourth", 32'(dout), 32'h044);
    do_read();
    check("empty_read_hold", 32'(dout), 32'h044);
    chk_en = 1'b0;
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    settle();
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Reset during data bit 3 with a word already queued.
    send_frame(9'h077, 8, 0, 1'b0, -1, -1, 1'b1);
    chk_en = 1'b0;
    drive(1'b0, BAUD);
    drive(1'b1, 3 * BAUD);
    drive(1'b1, 8);
    rst_n = 1'b0;
    m_q.delete();
    m_last = '0;
    m_ovr = 1'b0;
    drive(1'b1, 5);
    rst_n = 1'b1;
    drive(1'b1, 3);
    check("mid_rst_level", 32'(level), 32'h0);
    check("mid_rst_dout", 32'(dout), 32'h0);
    settle();
    send_frame(9'h03C, 8, 0, 1'b0, -1, -1, 1'b1);
    check("after_rst_level", 32'(level), 32'h1);
    do_read();
    check("after_rst_dout", 32'(dout), 32'h03C);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
